// File: rtl/mdu_unit_pkg.sv
// Shared types for the multiply/divide unit.
// Op encoding and word typedefs used across the core.
package mdu_unit_pkg;

  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MADD  = 4'd4,
    MDU_MADDU = 4'd5,
    MDU_MSUB  = 4'd6,
    MDU_MSUBU = 4'd7,
    MDU_MTHI  = 4'd8,
    MDU_MTLO  = 4'd9
  } mdu_op_t;

  function automatic uint32_t mag32(
    input uint32_t v,
    input logic    sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative radix-2 unsigned restoring divider.
// First iteration happens on the start edge.
module mdu_div_core
  import mdu_unit_pkg::*;
#(
  parameter int unsigned ITERS = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start_i,
  input  logic    abort_i,
  input  uint32_t dividend_i,
  input  uint32_t divisor_i,
  output logic    done_o,
  output uint32_t quotient_o,
  output uint32_t remainder_o
);

  localparam int CW = $clog2(ITERS + 1);

  uint32_t       rem_q;
  uint32_t       quo_q;
  uint32_t       div_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  function automatic uint64_t step(
    input uint32_t rem,
    input uint32_t quo,
    input uint32_t d
  );
    logic [32:0] r;
    r = {rem, quo[31]};
    if (r >= {1'b0, d})
      return {32'(r - {1'b0, d}), quo[30:0], 1'b1};
    return {r[31:0], quo[30:0], 1'b0};
  endfunction

  // One shift/subtract per cycle until ITERS bits are produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      {rem_q, quo_q} <= step('0, dividend_i, divisor_i);
      div_q <= divisor_i;
      cnt_q <= CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CW'(ITERS)) begin
        run_q <= 1'b0;
      end else begin
        {rem_q, quo_q} <= step(rem_q, quo_q, div_q);
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign done_o      = run_q && (cnt_q == CW'(ITERS));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit feeding HI/LO.
// Result is a registered one-cycle pulse.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned DIV_ITERS  = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [63:0] hilo_i,
  output logic        result_valid,
  output logic [63:0] result,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CW = $clog2(MUL_STAGES + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  uint64_t       p_q, p_d;
  uint64_t       res_q, res_d;
  uint64_t       result_q, result_d;
  logic          rv_q, rv_d;

  mdu_op_t op_q;
  uint32_t a_q, b_q;
  uint64_t hilo_q;

  mdu_op_t op_i;
  logic    accept;
  logic    msgn, dsgn;
  uint64_t ax, bx, prod, acc;
  uint32_t quo, rem, q_fix, r_fix;
  logic    div_done, div_start;

  function automatic logic is_mul(input mdu_op_t o);
    return o inside {MDU_MULT, MDU_MULTU, MDU_MADD,
                     MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_mac(input mdu_op_t o);
    return o inside {MDU_MADD, MDU_MADDU,
                     MDU_MSUB, MDU_MSUBU};
  endfunction

  assign op_i   = mdu_op_t'(req_op);
  assign accept = req_valid && (state_q == S_IDLE)
                  && !flush;

  assign msgn = op_q inside {MDU_MULT, MDU_MADD, MDU_MSUB};
  assign ax   = msgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign bx   = msgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign prod = ax * bx;

  // Accumulate stage on the registered product
  always_comb begin
    acc = p_q;
    unique case (op_q)
      MDU_MADD, MDU_MADDU: acc = hilo_q + p_q;
      MDU_MSUB, MDU_MSUBU: acc = hilo_q - p_q;
      default:             acc = p_q;
    endcase
  end

  assign div_start = accept && (op_i inside {MDU_DIV, MDU_DIVU})
                     && (req_b != 32'd0);

  mdu_div_core #(.ITERS(DIV_ITERS)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .abort_i     (flush),
    .dividend_i  (mag32(req_a, op_i == MDU_DIV)),
    .divisor_i   (mag32(req_b, op_i == MDU_DIV)),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  assign dsgn  = (op_q == MDU_DIV);
  assign q_fix = (dsgn && (a_q[31] ^ b_q[31])) ? -quo : quo;
  assign r_fix = (dsgn && a_q[31]) ? -rem : rem;

  // Next-state, datapath staging and result pulse
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    res_d    = res_q;
    result_d = result_q;
    rv_d     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          unique case (1'b1)
            is_mul(op_i): begin
              state_d = S_MUL;
              cnt_d   = '0;
            end
            (op_i == MDU_DIV || op_i == MDU_DIVU):
              state_d = (req_b == 32'd0) ? S_FIX : S_DIV;
            (op_i == MDU_MTHI): begin
              state_d = S_DONE;
              res_d   = {req_a, hilo_i[31:0]};
            end
            (op_i == MDU_MTLO): begin
              state_d = S_DONE;
              res_d   = {hilo_i[63:32], req_a};
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_MUL: begin
          p_d = prod;
          if (cnt_q == CW'(MUL_STAGES - 1)) begin
            state_d = S_DONE;
            res_d   = acc;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DIV: if (div_done) state_d = S_FIX;
        S_FIX: begin
          state_d = S_DONE;
          res_d   = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF}
                                   : {r_fix, q_fix};
        end
        S_DONE: begin
          state_d  = S_IDLE;
          rv_d     = 1'b1;
          result_d = res_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      res_q    <= res_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  // Operand capture on accept; hilo only for accumulate ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MDU_MULT;
      a_q    <= '0;
      b_q    <= '0;
      hilo_q <= '0;
    end else if (accept) begin
      op_q <= op_i;
      a_q  <= req_a;
      b_q  <= req_b;
      if (is_mac(op_i)) hilo_q <= hilo_i;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = !req_ready;
  assign result_valid = rv_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit.
// Directed plan cases plus random ops vs reference model.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [63:0] hilo_i = '0;
  logic        result_valid;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mdu_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .hilo_i       (hilo_i),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input mdu_op_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] h);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (op)
      MDU_MULT:  return ps;
      MDU_MULTU: return pu;
      MDU_MADD:  return h + ps;
      MDU_MADDU: return h + pu;
      MDU_MSUB:  return h - ps;
      MDU_MSUBU: return h - pu;
      MDU_MTHI:  return {a, h[31:0]};
      MDU_MTLO:  return {h[63:32], a};
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input mdu_op_t op,
                                 input logic [31:0] b);
    if (op == MDU_MTHI || op == MDU_MTLO) return 1;
    if (op == MDU_DIV || op == MDU_DIVU)
      return (b == 0) ? 2 : 34;
    return 3;
  endfunction

  task automatic run_op(input string tag,
                        input mdu_op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] h);
    logic [63:0] exp;
    int lat;
    int k;
    exp = ref_res(op, a, b, h);
    lat = ref_lat(op, b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    hilo_i = h;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hilo_i = {$urandom, $urandom};
    req_a = $urandom;
    req_b = $urandom;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (result_valid) break;
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " result"}, result, exp);
    @(posedge clk);
    #1;
    chk({tag, " one-pulse"}, 64'(result_valid), 64'd0);
    chk({tag, " hold"}, result, exp);
  endtask

  initial begin
    int k;
    int pulses;
    int t1, t2;
    logic [63:0] r1, r2;
    mdu_op_t op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst valid", 64'(result_valid), 64'd0);
    chk("rst result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 64'd0);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0);
    run_op("div neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 64'd0);
    run_op("divz", MDU_DIVU, 32'h1234, 32'd0, 64'd0);
    run_op("div ovf", MDU_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 64'd0);
    run_op("madd", MDU_MADD, 32'd3, 32'd4,
           64'h0000_0001_0000_0000);
    run_op("msubu", MDU_MSUBU, 32'd1, 32'd1, 64'd0);
    run_op("mtlo", MDU_MTLO, 32'hAB, 32'd0,
           64'h0000_0005_0000_0000);
    run_op("mthi", MDU_MTHI, 32'hCAFE, 32'd0,
           64'h1111_2222_3333_4444);

    for (int i = 0; i < 24; i++) begin
      op = mdu_op_t'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i == 5) begin
        op = MDU_DIV;
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op("rand", op, a, b, {$urandom, $urandom});
    end

    // flush mid-divide at edge E10
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MDU_DIV;
    req_a = 32'd1000;
    req_b = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush ready", 64'(req_ready), 64'd1);
    chk("flush busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    chk("flush no pulse", 64'(pulses), 64'd0);
    run_op("post-flush", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 64'd0);

    // flush while in DONE suppresses the pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MDU_MTHI;
    req_a = 32'h55;
    flush = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush done pulse", 64'(result_valid), 64'd0);
    chk("flush done ready", 64'(req_ready), 64'd1);

    // async reset mid-divide
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MDU_DIVU;
    req_a = 32'hFFFF;
    req_b = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst ready", 64'(req_ready), 64'd1);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst result", result, 64'd0);
    chk("arst valid", 64'(result_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back MULTs with req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MDU_MULT;
    req_a = 32'd6;
    req_b = 32'hFFFF_FFF9;
    @(posedge clk);
    #1;
    req_a = 32'h0001_0000;
    req_b = 32'h0003_0000;
    t1 = -1;
    t2 = -1;
    r1 = '0;
    r2 = '0;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) req_valid = 1'b0;
      if (result_valid && t1 < 0) begin
        t1 = k;
        r1 = result;
      end else if (result_valid && t2 < 0) begin
        t2 = k;
        r2 = result;
      end
    end
    chk("b2b first at", 64'(t1), 64'd3);
    chk("b2b gap", 64'(t2 - t1), 64'd4);
    chk("b2b r1", r1,
        ref_res(MDU_MULT, 32'd6, 32'hFFFF_FFF9, 64'd0));
    chk("b2b r2", r2,
        ref_res(MDU_MULT, 32'h0001_0000, 32'h0003_0000, 64'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide functional unit sitting directly upstream of the HI/LO register block in the OoO core.
- Accepts one HI/LO-writing instruction at a time and computes the 64-bit {hi,lo} result.
- Emits the result as a one-cycle pulse that drives the HI/LO block's data_valid/data_i.
- Reads the committed HI/LO value for accumulate ops.

Parameters:
- DIV_ITERS, 32, radix-2 divider iterations; equals operand width.
- MUL_STAGES, 2, multiplier pipeline depth before the accumulate stage.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts any in-flight op.
- req_valid  in  1  op request valid.
- req_ready  out  1  unit idle and able to accept.
- req_op  in  4  mdu_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- req_a  in  32  rs operand.
- req_b  in  32  rt operand.
- hilo_i  in  64  committed {hi,lo}.
- result_valid  out  1  one-cycle result pulse; feeds HI/LO data_valid.
- result  out  64  {hi,lo}; feeds HI/LO data_i.
- busy  out  1  op in flight (state != IDLE).

Behaviour:
- Reset (rst_n low, async): state IDLE, req_ready=1, result_valid=0, result=0, busy=0. Holds while rst_n low. Reset mid-operation discards all work.
- Accept: req_valid && req_ready && !flush at a rising edge (E0). Operands, op and hilo_i (MADD*/MSUB* only) are latched at E0. hilo_i is never re-read afterwards.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: accept MULT*/MADD*/MSUB* -> MUL. DIV/DIVU with req_b!=0 -> DIV. DIV/DIVU with req_b==0 -> FIX. MTHI/MTLO -> DONE.
- MUL: MUL_STAGES product cycles plus 1 accumulate cycle -> DONE. result_valid is high in the cycle after edge E3.
- DIV: one restoring iteration per cycle on operand magnitudes. After DIV_ITERS iterations -> FIX.
- FIX: sign correction -> DONE. Non-zero divide: result_valid high after E34. Divide by zero: high after E2.
- DONE: result_valid=1 for exactly one cycle; req_ready=0; -> IDLE. Next accept is possible at the following edge.
- req_ready=1 only in IDLE. busy=!req_ready.
- Arithmetic:
  - MULT: signed 32x32->64.
  - MULTU: unsigned.
  - MADD/MSUB: hilo_i ± signed product, mod 2^64.
  - MADDU/MSUBU: same with unsigned product.
  - MTHI: {req_a, hilo_i[31:0]}.
  - MTLO: {hilo_i[63:32], req_a}.
- Divide results: hi=remainder, lo=quotient.
  - Signed divide truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero: lo=0xFFFFFFFF, hi=req_a.
- result holds its last value outside result_valid. Only result_valid is qualifying.
- flush has priority over everything except reset. Any state -> IDLE at the next edge, with no result_valid pulse, even if in DONE.
- A req_valid coincident with flush is not accepted.
- No backpressure on the result: HI/LO always takes data_valid.

Decomposition:
- Shared package: mdu_op_t enum and uint64_t/uint32_t typedefs, added alongside existing cpu_defs types.
- mdu_state_t stays local to mdu_unit.
- One sub-module, mdu_div_core: iterative radix-2 unsigned restoring divider.
  - Interface: start, dividend, divisor, done, quotient, remainder, abort.
  - Sign handling and the special cases stay in mdu_unit.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> result_valid after E3, result=0xFFFFFFFF_FFFFFFFE. Same operands with MULTU -> 0x00000001_FFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> pulse after E34, result=0xFFFFFFFF_FFFFFFFD (hi=-1, lo=-3). DIVU 100/7 -> 0x00000002_0000000E.
- DIVU a=0x1234 b=0 -> pulse after E2, result=0x00001234_FFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- MADD hilo_i=0x00000001_00000000 a=3 b=4 -> 0x00000001_0000000C. MSUBU hilo_i=0 a=1 b=1 -> 0xFFFFFFFF_FFFFFFFF. MTLO a=0xAB with hilo_i=0x5_00000000 -> pulse after E1, result=0x00000005_000000AB.
- DIV accepted, flush asserted for the edge at cycle 10 -> no result_valid through cycle 40, req_ready=1 from cycle 11. A new MULT is then accepted and returns the correct result at +3.
- rst_n dropped asynchronously mid-divide -> req_ready=1, busy=0, result=0 immediately without a clock edge. Back-to-back MULT accepts in the cycle after each DONE -> two pulses 4 cycles apart.
